// File: rtl/base64_candidate_sequencer_if.sv
// Candidate stream bundle between the sequencer and a downstream hash core.
// Latency: n/a (wires only).
// Backpressure: valid/ready; the producer holds valid/data/raw until ready is seen.
interface base64_candidate_sequencer_if;
    logic        cand_valid;
    logic        cand_ready;
    logic [63:0] cand_data;
    logic [47:0] cand_raw;

    modport master (
        output cand_valid,
        output cand_data,
        output cand_raw,
        input  cand_ready
    );

    modport slave (
        input  cand_valid,
        input  cand_data,
        input  cand_raw,
        output cand_ready
    );
endinterface

// File: rtl/base64_candidate_sequencer.sv
// 8-lane base64 encoder: 48 raw bits -> 8 ASCII characters, lane k from bits [6k+5:6k].
// Latency: combinational.
// Backpressure: none.
module base64_enc8 (
    input  logic [47:0] raw,
    output logic [63:0] enc
);
    function automatic logic [7:0] b64_char(input logic [5:0] v);
        logic [7:0] c;
        if (v < 6'd26)      c = 8'd65 + {2'b00, v};            // 'A'..'Z'
        else if (v < 6'd52) c = 8'd97 + {2'b00, v} - 8'd26;    // 'a'..'z'
        else if (v < 6'd62) c = 8'd48 + {2'b00, v} - 8'd52;    // '0'..'9'
        else if (v == 6'd62) c = 8'h2B;                         // '+'
        else                c = 8'h2F;                          // '/'
        return c;
    endfunction

    for (genvar k = 0; k < 8; k++) begin : g_lane
        assign enc[8*k +: 8] = b64_char(raw[6*k +: 6]);
    end
endmodule

// Issues a run of base64-encoded candidates seed, seed+STEP, ... to a hash core.
// Latency: first candidate valid the cycle after an accepted start; one per cycle after that.
// Backpressure: candidate held stable while ready is low; abort/last transfer end the run via DONE.
module base64_candidate_sequencer #(
    parameter logic [47:0] STEP  = 48'd1,
    parameter int          CNT_W = 32
) (
    input  logic                         clk_i,
    input  logic                         rst_n_i,
    input  logic                         start_i,
    input  logic [47:0]                  seed_i,
    input  logic [CNT_W-1:0]             count_i,
    input  logic                         abort_i,
    base64_candidate_sequencer_if.master cand,
    output logic                         busy_o,
    output logic                         done_o,
    output logic [CNT_W-1:0]             issued_o
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [47:0]        raw_q, raw_d;
    logic [63:0]        enc_q, enc_d;
    logic [CNT_W-1:0]   rem_q, rem_d;
    logic [CNT_W-1:0]   issued_q, issued_d;

    logic [47:0]        raw_nxt;
    logic [47:0]        enc_in;
    logic [63:0]        enc_out;
    logic               xfer;

    // Single encoder: encodes the seed while idle, the next raw value while running,
    // so the encoded register always lands together with its raw value.
    assign raw_nxt = raw_q + STEP;
    assign enc_in  = (state_q == IDLE) ? seed_i : raw_nxt;

    base64_enc8 u_enc (
        .raw (enc_in),
        .enc (enc_out)
    );

    assign xfer = (state_q == RUN) && cand.cand_ready;

    // Next-state and datapath updates; a transfer coinciding with abort still counts.
    always_comb begin
        state_d  = state_q;
        raw_d    = raw_q;
        enc_d    = enc_q;
        rem_d    = rem_q;
        issued_d = issued_q;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    raw_d    = seed_i;
                    enc_d    = enc_out;
                    rem_d    = count_i;
                    issued_d = '0;
                    state_d  = (count_i != '0) ? RUN : DONE;
                end
            end
            RUN: begin
                if (xfer) begin
                    raw_d    = raw_nxt;
                    enc_d    = enc_out;
                    rem_d    = rem_q - CNT_W'(1);
                    issued_d = issued_q + CNT_W'(1);
                    if (rem_q == CNT_W'(1)) state_d = DONE;
                end
                if (abort_i) state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) state_q <= IDLE;
        else          state_q <= state_d;
    end

    // Candidate and counter registers; reset value of the encoded word is encode(0).
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            raw_q    <= '0;
            enc_q    <= 64'h4141_4141_4141_4141;
            rem_q    <= '0;
            issued_q <= '0;
        end else begin
            raw_q    <= raw_d;
            enc_q    <= enc_d;
            rem_q    <= rem_d;
            issued_q <= issued_d;
        end
    end

    assign cand.cand_valid = (state_q == RUN);
    assign cand.cand_data  = enc_q;
    assign cand.cand_raw   = raw_q;
    assign busy_o          = (state_q != IDLE);
    assign done_o          = (state_q == DONE);
    assign issued_o        = issued_q;
endmodule

// File: tb/tb_base64_candidate_sequencer.sv
// Directed bench for base64_candidate_sequencer: reset, basic run, wrap, zero count,
// busy start, backpressure ordering/stability, abort and reset mid-run.
module tb_base64_candidate_sequencer;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [47:0] seed;
    logic [31:0] count;
    logic        abort;
    logic        busy;
    logic        done;
    logic [31:0] issued;

    int tests_run    = 0;
    int tests_failed = 0;

    string alpha = "ABCDEFGHIJKLMNOPQRSTUVWXYZabcdefghijklmnopqrstuvwxyz0123456789+/";

    base64_candidate_sequencer_if cif ();

    base64_candidate_sequencer dut (
        .clk_i    (clk),
        .rst_n_i  (rst_n),
        .start_i  (start),
        .seed_i   (seed),
        .count_i  (count),
        .abort_i  (abort),
        .cand     (cif.master),
        .busy_o   (busy),
        .done_o   (done),
        .issued_o (issued)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] b64_model(input logic [47:0] r);
        logic [63:0] m;
        logic [5:0]  s;
        for (int k = 0; k < 8; k++) begin
            s = r[6*k +: 6];
            m[8*k +: 8] = alpha[s];
        end
        return m;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [47:0] s, input logic [31:0] c);
        start = 1'b1;
        seed  = s;
        count = c;
        step();
        start = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_valid"},  {63'd0, cif.cand_valid}, 64'd0);
        chk({tag, "_busy"},   {63'd0, busy},           64'd0);
        chk({tag, "_done"},   {63'd0, done},           64'd0);
        chk({tag, "_issued"}, {32'd0, issued},         64'd0);
        chk({tag, "_raw"},    {16'd0, cif.cand_raw},   64'd0);
        chk({tag, "_data"},   cif.cand_data,           64'h4141414141414141);
    endtask

    initial begin
        logic [47:0] exp_raw;
        logic [63:0] prev_data;
        logic        prev_hold;
        int          n_xfer;
        int          n_done;
        logic        ready_pat [8];

        rst_n = 1'b0; start = 1'b0; seed = '0; count = '0; abort = 1'b0;
        cif.cand_ready = 1'b0;
        step(); step();
        check_reset_values("reset");
        rst_n = 1'b1;
        step();

        // Basic run: seed 0, count 3, ready held high.
        cif.cand_ready = 1'b1;
        do_start(48'd0, 32'd3);
        chk("basic_valid0", {63'd0, cif.cand_valid}, 64'd1);
        chk("basic_raw0",   {16'd0, cif.cand_raw},   64'd0);
        chk("basic_data0",  cif.cand_data, 64'h4141414141414141);
        step();
        chk("basic_data1",  cif.cand_data, 64'h4141414141414142);
        step();
        chk("basic_data2",  cif.cand_data, 64'h4141414141414143);
        chk("basic_valid2", {63'd0, cif.cand_valid}, 64'd1);
        step();
        chk("basic_done",   {63'd0, done},           64'd1);
        chk("basic_vlow",   {63'd0, cif.cand_valid}, 64'd0);
        chk("basic_issued", {32'd0, issued},         64'd3);
        step();
        chk("basic_idle_done", {63'd0, done}, 64'd0);
        chk("basic_idle_busy", {63'd0, busy}, 64'd0);
        chk("basic_hold_raw",  {16'd0, cif.cand_raw}, 64'd3);
        chk("basic_hold_iss",  {32'd0, issued},       64'd3);

        // Abort in IDLE has no effect.
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("idle_abort_busy", {63'd0, busy}, 64'd0);

        // Wrap from all-ones to zero.
        do_start(48'hFFFF_FFFF_FFFF, 32'd2);
        chk("wrap_data0", cif.cand_data, 64'h2F2F2F2F2F2F2F2F);
        step();
        chk("wrap_raw1",  {16'd0, cif.cand_raw}, 64'd0);
        chk("wrap_data1", cif.cand_data, 64'h4141414141414141);
        step();
        chk("wrap_done",   {63'd0, done},   64'd1);
        chk("wrap_issued", {32'd0, issued}, 64'd2);
        step();

        // Zero count: straight to DONE, no candidate, issued cleared.
        do_start(48'd55, 32'd0);
        chk("zero_valid",  {63'd0, cif.cand_valid}, 64'd0);
        chk("zero_done",   {63'd0, done},           64'd1);
        chk("zero_issued", {32'd0, issued},         64'd0);
        step();
        chk("zero_done_off", {63'd0, done}, 64'd0);
        chk("zero_valid2",   {63'd0, cif.cand_valid}, 64'd0);

        // Start during RUN is ignored.
        cif.cand_ready = 1'b0;
        do_start(48'd1000, 32'd4);
        do_start(48'd9, 32'd1);
        chk("busy_start_raw",   {16'd0, cif.cand_raw},   64'd1000);
        chk("busy_start_valid", {63'd0, cif.cand_valid}, 64'd1);
        cif.cand_ready = 1'b1;
        step(); step(); step(); step();
        chk("busy_start_done",   {63'd0, done},   64'd1);
        chk("busy_start_issued", {32'd0, issued}, 64'd4);
        step();

        // Backpressure: irregular ready, scoreboard on order and stability.
        ready_pat = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        cif.cand_ready = 1'b0;
        do_start(48'd100, 32'd6);
        exp_raw   = 48'd100;
        n_xfer    = 0;
        prev_hold = 1'b0;
        prev_data = '0;
        for (int cyc = 0; cyc < 64; cyc++) begin
            if (done) break;
            if (cif.cand_valid) begin
                chk("bp_raw",  {16'd0, cif.cand_raw}, {16'd0, exp_raw});
                chk("bp_data", cif.cand_data, b64_model(exp_raw));
                if (prev_hold) chk("bp_stable", cif.cand_data, prev_data);
            end
            cif.cand_ready = ready_pat[cyc % 8];
            prev_hold = cif.cand_valid && !cif.cand_ready;
            prev_data = cif.cand_data;
            if (cif.cand_valid && cif.cand_ready) begin
                n_xfer++;
                exp_raw = exp_raw + 48'd1;
            end
            step();
        end
        chk("bp_done_seen", {63'd0, done},   64'd1);
        chk("bp_xfers",     64'(n_xfer),     64'd6);
        chk("bp_issued",    {32'd0, issued}, 64'd6);
        step();

        // Abort coinciding with the second transfer of a count-10 run.
        cif.cand_ready = 1'b1;
        n_done = 0;
        do_start(48'd500, 32'd10);
        step();
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("abort_issued", {32'd0, issued},         64'd2);
        chk("abort_valid",  {63'd0, cif.cand_valid}, 64'd0);
        if (done) n_done++;
        step();
        if (done) n_done++;
        step();
        if (done) n_done++;
        chk("abort_done_pulses", 64'(n_done), 64'd1);

        // Reset mid-run discards the run without a done pulse.
        cif.cand_ready = 1'b0;
        do_start(48'd7, 32'd10);
        step();
        rst_n = 1'b0;
        step();
        check_reset_values("rst_mid");
        rst_n = 1'b1;
        step();
        chk("rst_mid_done_after", {63'd0, done}, 64'd0);
        chk("rst_mid_busy_after", {63'd0, busy}, 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule

// File: doc/base64_candidate_sequencer.md
BASE64_CANDIDATE_SEQUENCER -- requirements
Module: base64_candidate_sequencer

Interface
REQ-001 The block SHALL have parameter STEP, default 1, giving the 48-bit increment between consecutive candidates (for interleaving across parallel hash cores).
REQ-002 The block SHALL have parameter CNT_W, default 32, giving the width of the candidate-count and issued-count fields.
REQ-003 clk_i  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst_n_i  input  1  reset, synchronous and active-low.
REQ-005 start_i  input  1  start request; sampled only in IDLE.
REQ-006 seed_i  input  48  first raw candidate value; latched on an accepted start.
REQ-007 count_i  input  CNT_W  number of candidates to issue; latched on an accepted start.
REQ-008 abort_i  input  1  terminate the current run.
REQ-009 cand_valid_o  output  1  candidate available downstream.
REQ-010 cand_ready_i  input  1  downstream accepts the candidate.
REQ-011 cand_data_o  output  64  ASCII-encoded candidate, 8 characters.
REQ-012 cand_raw_o  output  48  raw value matching cand_data_o.
REQ-013 busy_o  output  1  high in any state other than IDLE.
REQ-014 done_o  output  1  one-cycle end-of-run pulse.
REQ-015 issued_o  output  CNT_W  transfers completed since the last accepted start.

Function
REQ-016 Encoding: byte k of cand_data_o, bits [8k+7:8k], SHALL equal the standard base64 character (A-Z, a-z, 0-9, +, /) for cand_raw_o[6k+5:6k], k = 0..7, produced by instantiating the team's 8-lane base64 encoder.
REQ-017 The FSM SHALL have states IDLE, RUN and DONE.
REQ-018 IDLE: start_i=1 with count_i!=0 -> RUN; start_i=1 with count_i=0 -> DONE, with no candidate issued.
REQ-019 On an accepted start, the block SHALL load: raw register <= seed_i; encoded register <= encode(seed_i); remaining <= count_i; issued_o <= 0.
REQ-020 Latency: for a start accepted at edge N, cand_valid_o SHALL be high after edge N with cand_raw_o = seed_i.
REQ-021 A transfer SHALL occur on any edge where cand_valid_o and cand_ready_i are both 1.
REQ-022 Without a transfer, cand_valid_o, cand_data_o and cand_raw_o SHALL hold stable.
REQ-023 On a transfer, the block SHALL apply: raw <= raw + STEP (mod 2^48); encoded <= encode(raw + STEP); remaining decrements; issued_o increments.
REQ-024 Full throughput: with cand_ready_i held at 1, the block SHALL issue one candidate per cycle.
REQ-025 A transfer with remaining=1 SHALL move the FSM to DONE, and cand_valid_o SHALL be low on the next cycle.
REQ-026 abort_i=1 in RUN SHALL move the FSM to DONE, with cand_valid_o low on the next cycle.
REQ-027 If abort_i and a transfer coincide, the transfer SHALL count (issued_o increments) before the abort takes effect.
REQ-028 DONE SHALL last one cycle with done_o=1, then return to IDLE.
REQ-029 issued_o and cand_raw_o SHALL hold their values in IDLE until the next accepted start.
REQ-030 start_i SHALL be ignored in RUN and DONE; abort_i SHALL be ignored in IDLE and DONE.
REQ-031 The raw counter SHALL wrap from 0xFFFFFFFFFFFF to 0 (with STEP=1) without any flag or stall.
REQ-032 The issued counter SHALL wrap modulo 2^CNT_W.

Reset
REQ-033 rst_n_i=0 at an edge SHALL force: FSM=IDLE; cand_valid_o=0; busy_o=0; done_o=0; issued_o=0; cand_raw_o=0; cand_data_o=0x4141414141414141 ("AAAAAAAA").
REQ-034 Reset SHALL take priority over start_i, abort_i and any transfer.
REQ-035 Reset asserted mid-run SHALL discard the run, with no done_o pulse.

Verification
REQ-036 Basic run: seed 0, count 3, ready=1 -> data 0x4141414141414141, then 0x4141414141414142, then 0x4141414141414143; done_o pulses; issued_o=3.
REQ-037 Backpressure: ready toggles randomly -> exactly count_i transfers occur; data stays stable while valid=1 and ready=0; values arrive in order with no skips.
REQ-038 Wrap: seed 0xFFFFFFFFFFFF, count 2 -> 0x2F2F2F2F2F2F2F2F ("////////"), then 0x4141414141414141.
REQ-039 Zero count and busy start: count 0 -> done_o pulses one cycle after start, valid never asserts; a start during RUN is ignored.
REQ-040 Abort: abort_i coinciding with the 2nd transfer of a count-10 run -> issued_o=2, valid low next cycle, one done_o pulse.
REQ-041 Reset mid-run: rst_n_i low during RUN -> all outputs take the REQ-033 values next cycle, with no done_o pulse.
